// File: rtl/axi_tlp_dec_pkg.sv
// axi_tlp_dec_pkg
//   Shared definitions for the PCIe RX TLP decoder:
//   - fmt/type codes of the supported request TLPs (7-bit {fmt, type})
//   - completion status codes handed to the TLP encoder
//   - decoder FSM state constants
//   - request-kind enum and the header classification helpers
package axi_tlp_dec_pkg;

  // {fmt[1:0], type[4:0]} as found in DW0[30:24]
  localparam logic [6:0] MWR32  = 7'b10_00000;
  localparam logic [6:0] MRD32  = 7'b00_00000;
  localparam logic [6:0] CFGWR0 = 7'b10_00100;
  localparam logic [6:0] CFGRD0 = 7'b00_00100;

  localparam logic [2:0] CPL_SC = 3'd0;
  localparam logic [2:0] CPL_UR = 3'd1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;

  typedef enum logic [2:0] {
    K_UNSUP = 3'd0,  // anything not routed to a sink
    K_LWR   = 3'd1,  // AXI4-Lite write
    K_LRD   = 3'd2,  // AXI4-Lite read
    K_SWR   = 3'd3,  // AXI4-Stream write
    K_CWR   = 3'd4,  // config write
    K_CRD   = 3'd5   // config read
  } kind_t;

  // Requests that expect a completion: memory reads (3DW/4DW, locked),
  // IO requests and config requests of either type.
  function automatic logic is_non_posted(input logic [6:0] fmt_type);
    logic np;
    case (fmt_type[4:0])
      5'b00000, 5'b00001:          np = ~fmt_type[6];
      5'b00010, 5'b00100, 5'b00101: np = 1'b1;
      default:                     np = 1'b0;
    endcase
    return np;
  endfunction

  function automatic kind_t classify(input logic [6:0] fmt_type,
                                     input logic       lite_hit,
                                     input logic       stream_hit);
    kind_t k;
    k = K_UNSUP;
    if (fmt_type == MWR32 && lite_hit)        k = K_LWR;
    else if (fmt_type == MWR32 && stream_hit) k = K_SWR;
    else if (fmt_type == MRD32 && lite_hit)   k = K_LRD;
    else if (fmt_type == CFGWR0)              k = K_CWR;
    else if (fmt_type == CFGRD0)              k = K_CRD;
    return k;
  endfunction

endpackage

// File: rtl/axi_tlp_dec.sv
// axi_tlp_dec
//   PCIe RX TLP decoder on a 64-bit AXI4-Stream RX interface
//   (DW0 = tdata[31:0], DW1 = tdata[63:32]). Classifies each TLP by
//   fmt/type and BAR hit and routes it to the AXI4-Lite command port,
//   the AXI4-Stream write port or the config-space port; non-posted
//   requests get completion header fields and a completion request for
//   the TLP encoder.
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   tvalid/tdata/tlast  RX stream in; tready out; tstrb ignored
//   tuser[8:2]          BAR-hit vector; other tuser bits ignored
//   lnk_up              link up; no TLP accepted while low, aborts packet
//   tlp_enc_ready       encoder idle; a new TLP starts only while high
//   a4lm_*              AXI4-Lite command: addr, wr_data, to_start pulse,
//                       wr_cmd/rd_cmd direction qualifiers
//   cfg_*               config access: addr, wr_data, rd/wr pulses
//   a4sm_*              stream word: go pulse, data, addr
//   req_compl(_w_data)  completion request pulses, compl_code status
//   tenc_*              completion header fields for the encoder
module axi_tlp_dec
  import axi_tlp_dec_pkg::*;
#(
  parameter int LITE_BAR   = 4,
  parameter int STREAM_BAR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tvalid,
  input  logic [63:0] tdata,
  output logic        tready,
  input  logic [7:0]  tstrb,
  input  logic [21:0] tuser,
  input  logic        tlast,
  input  logic        lnk_up,
  input  logic        tlp_enc_ready,
  output logic [7:0]  a4lm_addr,
  output logic [31:0] a4lm_wr_data,
  output logic        a4lm_to_start,
  output logic        a4lm_wr_cmd,
  output logic        a4lm_rd_cmd,
  output logic [7:0]  cfg_addr,
  output logic [31:0] cfg_wr_data,
  output logic        cfg_rd_cmd,
  output logic        cfg_wr_cmd,
  output logic        a4sm_go,
  output logic [63:0] a4sm_data,
  output logic [7:0]  a4sm_addr,
  output logic        req_compl,
  output logic        req_compl_w_data,
  output logic [2:0]  compl_code,
  output logic [2:0]  tenc_tc,
  output logic [1:0]  tenc_attr,
  output logic [9:0]  tenc_len,
  output logic [15:0] tenc_rid,
  output logic [7:0]  tenc_tag,
  output logic [7:0]  tenc_be,
  output logic [12:0] tenc_addr
);

  logic [2:0] state;
  logic       tready_q;
  kind_t      kind;
  logic       np;
  logic [7:0] sm_addr_q;

  logic       beat;
  logic       sm_go;
  kind_t      exec_kind;
  logic       exec_np;
  logic       unused_inputs;

  // Byte strobes and the non-BAR tuser bits carry nothing for this decoder.
  assign unused_inputs = ^{tstrb, tuser};

  // A beat counts only on the handshake with the link still up; a beat
  // presented while the link drops is treated as part of the abort.
  assign beat  = tvalid & tready_q & lnk_up;
  assign sm_go = beat && (state == ST_DRAIN) && (kind == K_SWR);

  // A TLP ending on its header beat never delivered DW2, so it cannot be
  // routed to any sink; only its posted/non-posted nature still matters.
  assign exec_kind = (state == ST_HDR) ? K_UNSUP : kind;
  assign exec_np   = (state == ST_HDR) ? is_non_posted(tdata[30:24]) : np;

  assign tready    = tready_q;
  assign a4sm_go   = sm_go;
  assign a4sm_data = sm_go ? tdata : 64'd0;
  assign a4sm_addr = sm_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      tready_q         <= 1'b0;
      kind             <= K_UNSUP;
      np               <= 1'b0;
      sm_addr_q        <= 8'd0;
      a4lm_addr        <= 8'd0;
      a4lm_wr_data     <= 32'd0;
      a4lm_to_start    <= 1'b0;
      a4lm_wr_cmd      <= 1'b0;
      a4lm_rd_cmd      <= 1'b0;
      cfg_addr         <= 8'd0;
      cfg_wr_data      <= 32'd0;
      cfg_rd_cmd       <= 1'b0;
      cfg_wr_cmd       <= 1'b0;
      req_compl        <= 1'b0;
      req_compl_w_data <= 1'b0;
      compl_code       <= CPL_SC;
      tenc_tc          <= 3'd0;
      tenc_attr        <= 2'd0;
      tenc_len         <= 10'd0;
      tenc_rid         <= 16'd0;
      tenc_tag         <= 8'd0;
      tenc_be          <= 8'd0;
      tenc_addr        <= 13'd0;
    end else begin
      // Command outputs are single-cycle pulses, raised only for EXEC.
      a4lm_to_start    <= 1'b0;
      a4lm_wr_cmd      <= 1'b0;
      a4lm_rd_cmd      <= 1'b0;
      cfg_rd_cmd       <= 1'b0;
      cfg_wr_cmd       <= 1'b0;
      req_compl        <= 1'b0;
      req_compl_w_data <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (tvalid && lnk_up && tlp_enc_ready) begin
            state    <= ST_HDR;
            tready_q <= 1'b1;
          end
        end

        ST_HDR, ST_DATA, ST_DRAIN: begin
          if (!lnk_up) begin
            state    <= ST_IDLE;
            tready_q <= 1'b0;
          end else if (beat) begin
            // Header beat: DW0/DW1 fields and the request kind
            if (state == ST_HDR) begin
              kind      <= classify(tdata[30:24], tuser[2 + LITE_BAR],
                                    tuser[2 + STREAM_BAR]);
              np        <= is_non_posted(tdata[30:24]);
              tenc_tc   <= tdata[22:20];
              tenc_attr <= tdata[13:12];
              tenc_len  <= tdata[9:0];
              tenc_rid  <= tdata[63:48];
              tenc_tag  <= tdata[47:40];
              tenc_be   <= tdata[39:32];
            end

            // Address beat: DW2 in the low half, first payload DW high
            if (state == ST_DATA) begin
              tenc_addr <= tdata[12:0];
              case (kind)
                K_LWR: begin
                  a4lm_addr    <= tdata[7:0];
                  a4lm_wr_data <= tdata[63:32];
                end
                K_LRD: a4lm_addr <= tdata[7:0];
                K_CWR: begin
                  cfg_addr    <= tdata[7:0];
                  cfg_wr_data <= tdata[63:32];
                end
                K_CRD: cfg_addr  <= tdata[7:0];
                K_SWR: sm_addr_q <= tdata[7:0];
                default: ;
              endcase
            end

            if (sm_go) sm_addr_q <= sm_addr_q + 8'd8;

            if (tlast) begin
              state    <= ST_EXEC;
              tready_q <= 1'b0;
              case (exec_kind)
                K_LWR: begin
                  a4lm_to_start <= 1'b1;
                  a4lm_wr_cmd   <= 1'b1;
                end
                K_LRD: begin
                  a4lm_to_start    <= 1'b1;
                  a4lm_rd_cmd      <= 1'b1;
                  req_compl_w_data <= 1'b1;
                  compl_code       <= CPL_SC;
                end
                K_CWR: begin
                  cfg_wr_cmd <= 1'b1;
                  req_compl  <= 1'b1;
                  compl_code <= CPL_SC;
                end
                K_CRD: begin
                  cfg_rd_cmd       <= 1'b1;
                  req_compl_w_data <= 1'b1;
                  compl_code       <= CPL_SC;
                end
                K_SWR: ;
                default: begin
                  if (exec_np) begin
                    req_compl  <= 1'b1;
                    compl_code <= CPL_UR;
                  end
                end
              endcase
            end else begin
              state <= (state == ST_HDR) ? ST_DATA : ST_DRAIN;
            end
          end
        end

        ST_EXEC: state <= ST_IDLE;

        default: begin
          state    <= ST_IDLE;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_tlp_dec.sv
// tb_axi_tlp_dec
//   Directed scenarios for each routing case plus randomized TLPs checked
//   against a table-driven reference model of the decoder's routing rules.
module tb_axi_tlp_dec;

  logic        clk;
  logic        reset;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tready;
  logic [7:0]  tstrb;
  logic [21:0] tuser;
  logic        tlast;
  logic        lnk_up;
  logic        tlp_enc_ready;
  logic [7:0]  a4lm_addr;
  logic [31:0] a4lm_wr_data;
  logic        a4lm_to_start, a4lm_wr_cmd, a4lm_rd_cmd;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_rd_cmd, cfg_wr_cmd;
  logic        a4sm_go;
  logic [63:0] a4sm_data;
  logic [7:0]  a4sm_addr;
  logic        req_compl, req_compl_w_data;
  logic [2:0]  compl_code;
  logic [2:0]  tenc_tc;
  logic [1:0]  tenc_attr;
  logic [9:0]  tenc_len;
  logic [15:0] tenc_rid;
  logic [7:0]  tenc_tag;
  logic [7:0]  tenc_be;
  logic [12:0] tenc_addr;

  axi_tlp_dec dut (
    .clk(clk), .reset(reset), .tvalid(tvalid), .tdata(tdata), .tready(tready),
    .tstrb(tstrb), .tuser(tuser), .tlast(tlast), .lnk_up(lnk_up),
    .tlp_enc_ready(tlp_enc_ready), .a4lm_addr(a4lm_addr),
    .a4lm_wr_data(a4lm_wr_data), .a4lm_to_start(a4lm_to_start),
    .a4lm_wr_cmd(a4lm_wr_cmd), .a4lm_rd_cmd(a4lm_rd_cmd),
    .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data), .cfg_rd_cmd(cfg_rd_cmd),
    .cfg_wr_cmd(cfg_wr_cmd), .a4sm_go(a4sm_go), .a4sm_data(a4sm_data),
    .a4sm_addr(a4sm_addr), .req_compl(req_compl),
    .req_compl_w_data(req_compl_w_data), .compl_code(compl_code),
    .tenc_tc(tenc_tc), .tenc_attr(tenc_attr), .tenc_len(tenc_len),
    .tenc_rid(tenc_rid), .tenc_tag(tenc_tag), .tenc_be(tenc_be),
    .tenc_addr(tenc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [223:0] all_out;
  assign all_out = {tready, a4lm_addr, a4lm_wr_data, a4lm_to_start, a4lm_wr_cmd,
                    a4lm_rd_cmd, cfg_addr, cfg_wr_data, cfg_rd_cmd, cfg_wr_cmd,
                    a4sm_go, a4sm_data, a4sm_addr, req_compl, req_compl_w_data,
                    compl_code, tenc_tc, tenc_attr, tenc_len, tenc_rid, tenc_tag,
                    tenc_be, tenc_addr};

  // Event monitor: counts every pulse and logs stream words, sampled mid-cycle.
  int c_start = 0, c_wr = 0, c_rd = 0, c_cwr = 0, c_crd = 0, c_rc = 0, c_rcd = 0;
  logic [2:0]  code_seen = 3'd7;
  logic [7:0]  go_addr_q[$];
  logic [63:0] go_data_q[$];

  always @(negedge clk) begin
    if (a4lm_to_start) c_start++;
    if (a4lm_wr_cmd) c_wr++;
    if (a4lm_rd_cmd) c_rd++;
    if (cfg_wr_cmd) c_cwr++;
    if (cfg_rd_cmd) c_crd++;
    if (req_compl) c_rc++;
    if (req_compl_w_data) c_rcd++;
    if (req_compl || req_compl_w_data) code_seen = compl_code;
    if (a4sm_go) begin
      go_addr_q.push_back(a4sm_addr);
      go_data_q.push_back(a4sm_data);
    end
  end

  typedef struct {
    int start, wr, rd, cwr, crd, rc, rcd, go;
  } cnt_t;

  function automatic cnt_t now_cnt();
    cnt_t c;
    c.start = c_start; c.wr = c_wr; c.rd = c_rd; c.cwr = c_cwr;
    c.crd = c_crd; c.rc = c_rc; c.rcd = c_rcd; c.go = go_addr_q.size();
    return c;
  endfunction

  // Pulse-count deltas packed as {start, wr, rd, cfg_wr, cfg_rd, cpl, cpld}.
  function automatic logic [27:0] pulses(input cnt_t a, input cnt_t b);
    return {4'(b.start - a.start), 4'(b.wr - a.wr), 4'(b.rd - a.rd),
            4'(b.cwr - a.cwr), 4'(b.crd - a.crd), 4'(b.rc - a.rc),
            4'(b.rcd - a.rcd)};
  endfunction

  function automatic logic [27:0] exp_vec(input int s, input int w, input int r,
                                          input int cw, input int cr,
                                          input int rc, input int rcd);
    return {4'(s), 4'(w), 4'(r), 4'(cw), 4'(cr), 4'(rc), 4'(rcd)};
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic last, output bit ok);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    ok     = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (tready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
  endtask

  task automatic send_pkt(input logic [63:0] b[8], input int n, input logic [21:0] user,
                          input int maxgap, output bit ok, output logic rdy_exec,
                          output logic rdy_idle);
    bit bok;
    ok    = 1'b1;
    tuser = user;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 0);
        if (g > 0) begin
          tvalid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
      send_beat(b[i], (i == n - 1), bok);
      if (!bok) ok = 1'b0;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    @(negedge clk);
    rdy_exec = tready;
    @(negedge clk);
    rdy_idle = tready;
  endtask

  task automatic test_reset();
    reset = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tstrb = '0;
    tuser = '0; lnk_up = 1'b1; tlp_enc_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lite_write();
    logic [63:0] b[8];
    cnt_t c0, c1; bit ok; logic re, ri;
    b[0] = 64'h01a0090f40000001; b[1] = 64'h04f302f100000010;
    c0 = now_cnt();
    send_pkt(b, 2, 22'h000040, 0, ok, re, ri);
    c1 = now_cnt();
    n_cmp++;
    if (!ok || pulses(c0, c1) !== exp_vec(1, 1, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL lite_wr_pulses: got %h ok=%0d want %h", pulses(c0, c1), ok, exp_vec(1, 1, 0, 0, 0, 0, 0));
    end
    n_cmp++;
    if ({a4lm_addr, a4lm_wr_data} !== {8'h10, 32'h04f302f1}) begin
      n_fail++;
      $display("FAIL lite_wr_addr_data: got %h %h want 10 04f302f1", a4lm_addr, a4lm_wr_data);
    end
    n_cmp++;
    if ({tenc_rid, tenc_tag, tenc_be, tenc_len} !== {16'h01a0, 8'h09, 8'h0f, 10'd1}) begin
      n_fail++;
      $display("FAIL lite_wr_tenc: got %h %h %h %0d want 01a0 09 0f 1", tenc_rid, tenc_tag, tenc_be, tenc_len);
    end
  endtask

  task automatic test_stream_write();
    logic [63:0] b[8];
    cnt_t c0, c1; bit ok; logic re, ri;
    b[0] = 64'h01a00a0f40000001; b[1] = 64'hb4a3a2b100000010;
    b[2] = 64'ha6c8b4f20fc4d8a5; b[3] = 64'hb4f7c9a0d5c6a2f6;
    c0 = now_cnt();
    send_pkt(b, 4, 22'h000004, 0, ok, re, ri);
    c1 = now_cnt();
    n_cmp++;
    if (!ok || pulses(c0, c1) !== '0 || c1.go - c0.go != 2) begin
      n_fail++;
      $display("FAIL stream_counts: got pulses %h words %0d want 0 and 2", pulses(c0, c1), c1.go - c0.go);
    end else begin
      n_cmp++;
      if ({go_addr_q[c0.go], go_data_q[c0.go], go_addr_q[c0.go + 1], go_data_q[c0.go + 1]} !==
          {8'h10, 64'ha6c8b4f20fc4d8a5, 8'h18, 64'hb4f7c9a0d5c6a2f6}) begin
        n_fail++;
        $display("FAIL stream_words: got %h/%h %h/%h want 10/a6c8b4f20fc4d8a5 18/b4f7c9a0d5c6a2f6",
                 go_addr_q[c0.go], go_data_q[c0.go], go_addr_q[c0.go + 1], go_data_q[c0.go + 1]);
      end
    end
  endtask

  task automatic test_cfg_write();
    logic [63:0] b[8];
    cnt_t c0, c1; bit ok; logic re, ri;
    b[0] = 64'h01a00b0f44000001; b[1] = 64'hd6f8a2c5000000c4; b[2] = 64'h00000000a6d8c5f4;
    c0 = now_cnt();
    send_pkt(b, 3, 22'h000000, 0, ok, re, ri);
    c1 = now_cnt();
    n_cmp++;
    if (!ok || pulses(c0, c1) !== exp_vec(0, 0, 0, 1, 0, 1, 0) || code_seen !== 3'd0) begin
      n_fail++;
      $display("FAIL cfg_wr_pulses: got %h code %0d ok=%0d want %h code 0", pulses(c0, c1), code_seen, ok, exp_vec(0, 0, 0, 1, 0, 1, 0));
    end
    n_cmp++;
    if ({cfg_addr, cfg_wr_data, tenc_tag} !== {8'hc4, 32'hd6f8a2c5, 8'h0b}) begin
      n_fail++;
      $display("FAIL cfg_wr_fields: got %h %h %h want c4 d6f8a2c5 0b", cfg_addr, cfg_wr_data, tenc_tag);
    end
  endtask

  task automatic test_gating();
    cnt_t c0, c1; logic seen;
    c0 = now_cnt();
    tdata = 64'h01a0090f40000001; tuser = 22'h000040; tlast = 1'b0;
    tvalid = 1'b1; lnk_up = 1'b0; seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= tready; end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_lnk_down: tready got 1 want 0");
    end
    lnk_up = 1'b1; tlp_enc_ready = 1'b0; seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= tready; end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_enc_busy: tready got 1 want 0");
    end
    tvalid = 1'b0; tlp_enc_ready = 1'b1;
    repeat (2) @(negedge clk);
    c1 = now_cnt();
    n_cmp++;
    if (pulses(c0, c1) !== '0 || c1.go != c0.go) begin
      n_fail++;
      $display("FAIL gate_no_cmd: got %h want 0", pulses(c0, c1));
    end
  endtask

  task automatic test_lite_read();
    logic [63:0] b[8];
    cnt_t c0, c1; bit ok; logic re, ri;
    b[0] = 64'h01a00c0f00000001; b[1] = 64'h0000000000000020;
    c0 = now_cnt();
    send_pkt(b, 2, 22'h000040, 0, ok, re, ri);
    c1 = now_cnt();
    n_cmp++;
    if (!ok || pulses(c0, c1) !== exp_vec(1, 0, 1, 0, 0, 0, 1) || code_seen !== 3'd0) begin
      n_fail++;
      $display("FAIL lite_rd_pulses: got %h code %0d want %h code 0", pulses(c0, c1), code_seen, exp_vec(1, 0, 1, 0, 0, 0, 1));
    end
    n_cmp++;
    if ({a4lm_addr, tenc_addr, tenc_tag} !== {8'h20, 13'h0020, 8'h0c}) begin
      n_fail++;
      $display("FAIL lite_rd_addr: got %h %h %h want 20 0020 0c", a4lm_addr, tenc_addr, tenc_tag);
    end
  endtask

  task automatic test_mrd_stream_bar();
    logic [63:0] b[8];
    cnt_t c0, c1; bit ok; logic re, ri;
    b[0] = 64'h01a00d0f00000001; b[1] = 64'h0000000000000040; b[2] = 64'h123456789abcdef0;
    c0 = now_cnt();
    send_pkt(b, 3, 22'h000004, 0, ok, re, ri);
    c1 = now_cnt();
    n_cmp++;
    if (!ok || pulses(c0, c1) !== exp_vec(0, 0, 0, 0, 0, 1, 0) || code_seen !== 3'd1 || c1.go != c0.go) begin
      n_fail++;
      $display("FAIL mrd_bar0_ur: got %h code %0d ok=%0d want %h code 1", pulses(c0, c1), code_seen, ok, exp_vec(0, 0, 0, 0, 0, 1, 0));
    end
    n_cmp++;
    if ({re, ri} !== 2'b00) begin
      n_fail++;
      $display("FAIL mrd_gap_tready: got %b want 00", {re, ri});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] b[8];
    cnt_t c0, c1; bit ok1, ok2; logic re, ri;
    c0 = now_cnt();
    b[0] = 64'h22220e0f04000001; b[1] = 64'h0000000000000088;
    send_pkt(b, 2, 22'h000000, 0, ok1, re, ri);
    b[0] = 64'h33330f0f40000001; b[1] = 64'hcafef00d000000e4;
    send_pkt(b, 2, 22'h000040, 0, ok2, re, ri);
    c1 = now_cnt();
    n_cmp++;
    if (!ok1 || !ok2 || pulses(c0, c1) !== exp_vec(1, 1, 0, 0, 1, 0, 1)) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %h want %h", pulses(c0, c1), exp_vec(1, 1, 0, 0, 1, 0, 1));
    end
    n_cmp++;
    if ({cfg_addr, a4lm_addr, a4lm_wr_data, tenc_rid} !== {8'h88, 8'he4, 32'hcafef00d, 16'h3333}) begin
      n_fail++;
      $display("FAIL b2b_fields: got %h %h %h %h want 88 e4 cafef00d 3333", cfg_addr, a4lm_addr, a4lm_wr_data, tenc_rid);
    end
  endtask

  task automatic test_link_drop();
    logic [63:0] b[8];
    cnt_t c0, c1; bit ok; logic r, re, ri;
    c0 = now_cnt();
    tuser = 22'h000040;
    send_beat(64'h01a0110f40000001, 1'b0, ok);
    tdata = 64'h1122334400000030; tlast = 1'b1; tvalid = 1'b1; lnk_up = 1'b0;
    @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0; lnk_up = 1'b1;
    @(negedge clk);
    r = tready;
    repeat (3) @(negedge clk);
    c1 = now_cnt();
    n_cmp++;
    if (!ok || r !== 1'b0 || pulses(c0, c1) !== '0) begin
      n_fail++;
      $display("FAIL link_drop_abort: tready %b pulses %h ok=%0d want 0 0", r, pulses(c0, c1), ok);
    end
    c0 = now_cnt();
    b[0] = 64'h01a0120f40000001; b[1] = 64'h5566778800000034;
    send_pkt(b, 2, 22'h000040, 0, ok, re, ri);
    c1 = now_cnt();
    n_cmp++;
    if (!ok || pulses(c0, c1) !== exp_vec(1, 1, 0, 0, 0, 0, 0) || a4lm_addr !== 8'h34) begin
      n_fail++;
      $display("FAIL link_drop_recover: got %h addr %h want %h addr 34", pulses(c0, c1), a4lm_addr, exp_vec(1, 1, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] b[8];
    cnt_t c0, c1; bit ok; logic r, re, ri;
    logic [223:0] ao;
    tuser = 22'h000000;
    send_beat(64'h01a0130f44000001, 1'b0, ok);
    #2;
    reset = 1'b1; tvalid = 1'b0;
    #1;
    r = tready; ao = all_out;
    n_cmp++;
    if (!ok || r !== 1'b0 || ao !== '0) begin
      n_fail++;
      $display("FAIL async_reset: tready %b outs %h want all 0", r, ao);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    c0 = now_cnt();
    b[0] = 64'h01a0140f44000001; b[1] = 64'h0badbeef00000018;
    send_pkt(b, 2, 22'h000000, 0, ok, re, ri);
    c1 = now_cnt();
    n_cmp++;
    if (!ok || pulses(c0, c1) !== exp_vec(0, 0, 0, 1, 0, 1, 0) || {cfg_addr, cfg_wr_data} !== {8'h18, 32'h0badbeef}) begin
      n_fail++;
      $display("FAIL async_reset_recover: got %h %h %h want %h 18 0badbeef", pulses(c0, c1), cfg_addr, cfg_wr_data, exp_vec(0, 0, 0, 1, 0, 1, 0));
    end
  endtask

  // Request types the model knows, with whether each expects a completion.
  typedef struct {
    logic [6:0] ft;
    bit         nonposted;
  } req_t;

  task automatic test_random();
    req_t tbl[9];
    logic [63:0] b[8];
    cnt_t c0, c1; bit ok; logic re, ri;
    tbl[0] = '{7'b10_00000, 1'b0};  // MWr32
    tbl[1] = '{7'b00_00000, 1'b1};  // MRd32
    tbl[2] = '{7'b10_00100, 1'b1};  // CfgWr0
    tbl[3] = '{7'b00_00100, 1'b1};  // CfgRd0
    tbl[4] = '{7'b11_00000, 1'b0};  // MWr64
    tbl[5] = '{7'b01_00000, 1'b1};  // MRd64
    tbl[6] = '{7'b01_10000, 1'b0};  // Msg
    tbl[7] = '{7'b00_00010, 1'b1};  // IORd
    tbl[8] = '{7'b10_00101, 1'b1};  // CfgWr1
    for (int t = 0; t < 40; t++) begin
      int idx, bar, n;
      logic [2:0] tc; logic [1:0] attr; logic [9:0] len;
      logic [15:0] rid; logic [7:0] tag, be;
      logic [21:0] user;
      bit lite, str;
      int e_s, e_w, e_r, e_cw, e_cr, e_rc, e_rcd;
      logic [2:0] e_code;
      bit e_lite, e_cfg, e_str;
      idx = $urandom_range(8, 0);
      bar = $urandom_range(2, 0);
      if (bar == 2) bar = 4;
      n = ($urandom_range(9, 0) == 0) ? 1 : $urandom_range(5, 2);
      tc = 3'($urandom); attr = 2'($urandom); len = 10'($urandom);
      rid = 16'($urandom); tag = 8'($urandom); be = 8'($urandom);
      b[0] = {rid, tag, be, 1'b0, tbl[idx].ft, 1'b0, tc, 6'($urandom), attr, 2'b00, len};
      for (int i = 1; i < 8; i++) b[i] = {$urandom, $urandom};
      lite = (bar == 4);
      str  = (bar == 0);
      user = (22'($urandom) & 22'h3ffe03) | (22'd1 << (2 + bar));

      e_s = 0; e_w = 0; e_r = 0; e_cw = 0; e_cr = 0; e_rc = 0; e_rcd = 0;
      e_code = 3'd0; e_lite = 0; e_cfg = 0; e_str = 0;
      if (n >= 2 && idx == 0 && lite) begin
        e_s = 1; e_w = 1; e_lite = 1;
      end else if (n >= 2 && idx == 0 && str) begin
        e_str = 1;
      end else if (n >= 2 && idx == 1 && lite) begin
        e_s = 1; e_r = 1; e_rcd = 1; e_lite = 1;
      end else if (n >= 2 && idx == 2) begin
        e_cw = 1; e_rc = 1; e_cfg = 1;
      end else if (n >= 2 && idx == 3) begin
        e_cr = 1; e_rcd = 1; e_cfg = 1;
      end else if (tbl[idx].nonposted) begin
        e_rc = 1; e_code = 3'd1;
      end

      c0 = now_cnt();
      send_pkt(b, n, user, 2, ok, re, ri);
      c1 = now_cnt();

      n_cmp++;
      if (!ok || pulses(c0, c1) !== exp_vec(e_s, e_w, e_r, e_cw, e_cr, e_rc, e_rcd) || {re, ri} !== 2'b00) begin
        n_fail++;
        $display("FAIL rnd%0d_pulses: got %h rdy %b ok=%0d want %h (ft=%b bar=%0d n=%0d)",
                 t, pulses(c0, c1), {re, ri}, ok, exp_vec(e_s, e_w, e_r, e_cw, e_cr, e_rc, e_rcd), tbl[idx].ft, bar, n);
      end
      if (e_rc + e_rcd > 0) begin
        n_cmp++;
        if (code_seen !== e_code) begin
          n_fail++;
          $display("FAIL rnd%0d_code: got %0d want %0d", t, code_seen, e_code);
        end
      end
      n_cmp++;
      if ({tenc_tc, tenc_attr, tenc_len, tenc_rid, tenc_tag, tenc_be} !== {tc, attr, len, rid, tag, be} ||
          (n >= 2 && tenc_addr !== b[1][12:0])) begin
        n_fail++;
        $display("FAIL rnd%0d_tenc: got %h %h %h %h %h %h %h want %h %h %h %h %h %h %h", t,
                 tenc_tc, tenc_attr, tenc_len, tenc_rid, tenc_tag, tenc_be, tenc_addr,
                 tc, attr, len, rid, tag, be, b[1][12:0]);
      end
      if (e_lite) begin
        n_cmp++;
        if (a4lm_addr !== b[1][7:0] || (e_w == 1 && a4lm_wr_data !== b[1][63:32])) begin
          n_fail++;
          $display("FAIL rnd%0d_lite: got %h %h want %h %h", t, a4lm_addr, a4lm_wr_data, b[1][7:0], b[1][63:32]);
        end
      end
      if (e_cfg) begin
        n_cmp++;
        if (cfg_addr !== b[1][7:0] || (e_cw == 1 && cfg_wr_data !== b[1][63:32])) begin
          n_fail++;
          $display("FAIL rnd%0d_cfg: got %h %h want %h %h", t, cfg_addr, cfg_wr_data, b[1][7:0], b[1][63:32]);
        end
      end
      n_cmp++;
      if (c1.go - c0.go != (e_str ? n - 2 : 0)) begin
        n_fail++;
        $display("FAIL rnd%0d_stream_count: got %0d want %0d", t, c1.go - c0.go, e_str ? n - 2 : 0);
      end else if (e_str) begin
        for (int k = 0; k < n - 2; k++) begin
          logic [7:0] ea;
          ea = b[1][7:0] + 8'(8 * k);
          n_cmp++;
          if (go_addr_q[c0.go + k] !== ea || go_data_q[c0.go + k] !== b[k + 2]) begin
            n_fail++;
            $display("FAIL rnd%0d_stream_word%0d: got %h/%h want %h/%h", t, k,
                     go_addr_q[c0.go + k], go_data_q[c0.go + k], ea, b[k + 2]);
          end
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lite_write();
    test_stream_write();
    test_cfg_write();
    test_gating();
    test_lite_read();
    test_mrd_stream_bar();
    test_back_to_back();
    test_link_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
